exec_stage: RTL and testbench

- Execute stage of the 5-stage pipelined MIPS core.
- Takes decoded operands and controls from the ID/EX register and resolves data hazards by forwarding from MEM and WB.
- Computes the ALU result, selects the destination register, and holds the EX/MEM pipeline register internally.
- Outputs feed the memory stage; the MEM-forwarding source is the block's own EX/MEM register.

---
 rtl/exec_stage_pkg.sv | 24 ++
 rtl/alu_unit.sv | 47 ++++
 rtl/exec_stage.sv | 109 ++++++++++
 tb/tb_exec_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_stage_pkg.sv
// Shared definitions for the MIPS execute stage.
//   DATA_W / REG_AW : default datapath and register-index widths
//   ALUOP_*         : ALU class codes produced by the main decoder
//   FUNCT_*         : R-type function-field encodings understood by the ALU
package exec_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_unit.sv
// Purely combinational ALU for the execute stage.
//   op_a, op_b : operands (op_b is also the shift source for sll/srl)
//   aluop      : ALU class from the decoder
//   funct      : R-type function field, decoded when aluop is R-type
//   shamt      : shift amount for sll/srl
//   result     : ALU output; unknown R-type functions yield 0
module alu_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [1:0]        aluop,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    output logic [DATA_W-1:0] result
);

    import exec_stage_pkg::*;

    logic signed_lt;

    assign signed_lt = $signed(op_a) < $signed(op_b);

    always_comb begin
        result = '0;
        case (aluop)
            ALUOP_ADD: result = op_a + op_b;
            ALUOP_SUB: result = op_a - op_b;
            ALUOP_OR:  result = op_a | op_b;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: result = op_a + op_b;
                    FUNCT_SUB: result = op_a - op_b;
                    FUNCT_AND: result = op_a & op_b;
                    FUNCT_OR:  result = op_a | op_b;
                    FUNCT_NOR: result = ~(op_a | op_b);
                    FUNCT_SLT: result = {{(DATA_W-1){1'b0}}, signed_lt};
                    FUNCT_SLL: result = op_b << shamt;
                    FUNCT_SRL: result = op_b >> shamt;
                    default:   result = '0;
                endcase
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
// Inputs : ID/EX operands and controls (reg1/reg2, imm_ext, rs/rt/rd, funct, shamt,
//          regdst, alusrc, aluop, pass-through memtoreg/memread/memwrite/regwrite),
//          WB write-back port (wb_regwrite, wb_dst, wb_data) for forwarding.
// Outputs: alu_result_ex (combinational), and the EX/MEM register contents
//          mem_alu_result, mem_store_data, mem_dst, mem_memtoreg, mem_memread,
//          mem_memwrite, mem_regwrite.
// The EX/MEM register held here is also the MEM forwarding source.
module exec_stage #(
    parameter int unsigned DATA_W = exec_stage_pkg::DATA_W,
    parameter int unsigned REG_AW = exec_stage_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regdst,
    input  logic              alusrc,
    input  logic              memtoreg_in,
    input  logic              memread_in,
    input  logic              memwrite_in,
    input  logic              regwrite_in,
    input  logic [1:0]        aluop,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    input  logic [DATA_W-1:0] imm_ext,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] alu_result_ex,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_AW-1:0] mem_dst,
    output logic              mem_memtoreg,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic              mem_regwrite
);

    logic              mem_hit_a, mem_hit_b;
    logic              wb_hit_a, wb_hit_b;
    logic [DATA_W-1:0] fwd_a, fwd_b;
    logic [DATA_W-1:0] alu_b;
    logic [REG_AW-1:0] dst;

    // r0 is hard-wired to zero, so a write targeting it must never be forwarded.
    assign mem_hit_a = mem_regwrite && (mem_dst != '0) && (mem_dst == rs);
    assign mem_hit_b = mem_regwrite && (mem_dst != '0) && (mem_dst == rt);
    assign wb_hit_a  = wb_regwrite  && (wb_dst  != '0) && (wb_dst  == rs);
    assign wb_hit_b  = wb_regwrite  && (wb_dst  != '0) && (wb_dst  == rt);

    // MEM holds the younger result, so it takes priority over WB.
    always_comb begin
        fwd_a = reg1;
        if (mem_hit_a) begin
            fwd_a = mem_alu_result;
        end else if (wb_hit_a) begin
            fwd_a = wb_data;
        end
    end

    always_comb begin
        fwd_b = reg2;
        if (mem_hit_b) begin
            fwd_b = mem_alu_result;
        end else if (wb_hit_b) begin
            fwd_b = wb_data;
        end
    end

    assign alu_b = alusrc ? imm_ext : fwd_b;
    assign dst   = regdst ? rd : rt;

    alu_unit #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_a   (fwd_a),
        .op_b   (alu_b),
        .aluop  (aluop),
        .funct  (funct),
        .shamt  (shamt),
        .result (alu_result_ex)
    );

    // EX/MEM register; reset inserts a bubble and drops the in-flight instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_alu_result <= '0;
            mem_store_data <= '0;
            mem_dst        <= '0;
            mem_memtoreg   <= 1'b0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            mem_regwrite   <= 1'b0;
        end else begin
            mem_alu_result <= alu_result_ex;
            mem_store_data <= fwd_b;
            mem_dst        <= dst;
            mem_memtoreg   <= memtoreg_in;
            mem_memread    <= memread_in;
            mem_memwrite   <= memwrite_in;
            mem_regwrite   <= regwrite_in;
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
module tb_exec_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        regdst, alusrc;
    logic        memtoreg_in, memread_in, memwrite_in, regwrite_in;
    logic [1:0]  aluop;
    logic [31:0] reg1, reg2, imm_ext;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic        wb_regwrite;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic [31:0] alu_result_ex, mem_alu_result, mem_store_data;
    logic [4:0]  mem_dst;
    logic        mem_memtoreg, mem_memread, mem_memwrite, mem_regwrite;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exec_stage dut (
        .clk            (clk),
        .reset          (reset),
        .regdst         (regdst),
        .alusrc         (alusrc),
        .memtoreg_in    (memtoreg_in),
        .memread_in     (memread_in),
        .memwrite_in    (memwrite_in),
        .regwrite_in    (regwrite_in),
        .aluop          (aluop),
        .reg1           (reg1),
        .reg2           (reg2),
        .imm_ext        (imm_ext),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .funct          (funct),
        .shamt          (shamt),
        .wb_regwrite    (wb_regwrite),
        .wb_dst         (wb_dst),
        .wb_data        (wb_data),
        .alu_result_ex  (alu_result_ex),
        .mem_alu_result (mem_alu_result),
        .mem_store_data (mem_store_data),
        .mem_dst        (mem_dst),
        .mem_memtoreg   (mem_memtoreg),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .mem_regwrite   (mem_regwrite)
    );

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All-zero controls: a bubble with no forwarding sources.
    task automatic idle_inputs();
        reset = 1'b0; regdst = 1'b0; alusrc = 1'b0;
        memtoreg_in = 1'b0; memread_in = 1'b0; memwrite_in = 1'b0; regwrite_in = 1'b0;
        aluop = 2'b00; reg1 = '0; reg2 = '0; imm_ext = '0;
        rs = '0; rt = '0; rd = '0; funct = '0; shamt = '0;
        wb_regwrite = 1'b0; wb_dst = '0; wb_data = '0;
    endtask

    // Issue an R-type op with no forwarding and check the combinational result.
    task automatic rtype_op(input string name, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
        idle_inputs();
        aluop = 2'b10; funct = f; reg1 = a; reg2 = b; shamt = sh; rs = 5'd10; rt = 5'd11;
        #1;
        n_checks++;
        if (alu_result_ex !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, alu_result_ex, exp);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({mem_alu_result, mem_store_data, mem_dst, mem_memtoreg, mem_memread, mem_memwrite,
             mem_regwrite} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h/%h/%h/%b%b%b%b expected all zero", mem_alu_result,
                     mem_store_data, mem_dst, mem_memtoreg, mem_memread, mem_memwrite,
                     mem_regwrite);
        end
    endtask

    task automatic test_rtype_add();
        idle_inputs();
        reg1 = 32'd5; reg2 = 32'd7; aluop = 2'b10; funct = 6'b100000; regdst = 1'b1;
        rs = 5'd1; rt = 5'd2; rd = 5'd3; regwrite_in = 1'b1;
        #1;
        n_checks++;
        if (alu_result_ex !== 32'd12) begin
            n_fail++; $display("FAIL add_comb: got %0d expected 12", alu_result_ex);
        end
        tick();
        n_checks++;
        if (mem_alu_result !== 32'd12) begin
            n_fail++; $display("FAIL add_reg: got %0d expected 12", mem_alu_result);
        end
        n_checks++;
        if (mem_dst !== 5'd3 || mem_regwrite !== 1'b1) begin
            n_fail++;
            $display("FAIL add_dst: got dst %0d rw %b expected 3 1", mem_dst, mem_regwrite);
        end
    endtask

    // Relies on r3 = 12 sitting in EX/MEM from test_rtype_add.
    task automatic test_mem_forward();
        idle_inputs();
        aluop = 2'b10; funct = 6'b100000; rs = 5'd3; reg1 = 32'd0; rt = 5'd5; reg2 = 32'd1;
        wb_regwrite = 1'b1; wb_dst = 5'd3; wb_data = 32'd99;
        regdst = 1'b1; rd = 5'd6; regwrite_in = 1'b1;
        #1;
        n_checks++;
        if (alu_result_ex !== 32'd13) begin
            n_fail++; $display("FAIL mem_priority: got %0d expected 13", alu_result_ex);
        end
        tick();
    endtask

    // EX/MEM now targets r6, so only WB can match rt=4.
    task automatic test_wb_store();
        idle_inputs();
        aluop = 2'b00; alusrc = 1'b1; rs = 5'd1; reg1 = 32'h200; imm_ext = 32'd8;
        rt = 5'd4; reg2 = 32'd0; memwrite_in = 1'b1;
        wb_regwrite = 1'b1; wb_dst = 5'd4; wb_data = 32'hABCD;
        tick();
        n_checks++;
        if (mem_store_data !== 32'hABCD) begin
            n_fail++; $display("FAIL wb_store: got %h expected 0000abcd", mem_store_data);
        end
        n_checks++;
        if (mem_alu_result !== 32'h208 || mem_memwrite !== 1'b1 || mem_regwrite !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_addr: got %h w%b rw%b expected 00000208 w1 rw0", mem_alu_result,
                     mem_memwrite, mem_regwrite);
        end
    endtask

    task automatic test_lw();
        idle_inputs();
        aluop = 2'b00; alusrc = 1'b1; rs = 5'd2; reg1 = 32'h100; imm_ext = 32'hFFFF_FFFC;
        rt = 5'd8; regdst = 1'b0; rd = 5'd9;
        memread_in = 1'b1; memtoreg_in = 1'b1; regwrite_in = 1'b1;
        tick();
        n_checks++;
        if (mem_alu_result !== 32'hFC) begin
            n_fail++; $display("FAIL lw_addr: got %h expected 000000fc", mem_alu_result);
        end
        n_checks++;
        if (mem_dst !== 5'd8 || {mem_memread, mem_memtoreg, mem_regwrite, mem_memwrite} !== 4'b1110)
        begin
            n_fail++;
            $display("FAIL lw_ctrl: got dst %0d rd%b m2r%b rw%b w%b expected 8 1 1 1 0", mem_dst,
                     mem_memread, mem_memtoreg, mem_regwrite, mem_memwrite);
        end
    endtask

    task automatic test_r0_no_forward();
        idle_inputs();
        aluop = 2'b10; funct = 6'b100000; reg1 = 32'd5; reg2 = 32'd7; rs = 5'd1; rt = 5'd2;
        regdst = 1'b1; rd = 5'd0; regwrite_in = 1'b1;
        tick();
        idle_inputs();
        aluop = 2'b10; funct = 6'b100101; rs = 5'd0; rt = 5'd0;
        wb_regwrite = 1'b1; wb_dst = 5'd0; wb_data = 32'd55;
        #1;
        n_checks++;
        if (alu_result_ex !== 32'd0) begin
            n_fail++; $display("FAIL r0_forward: got %h expected 0", alu_result_ex);
        end
    endtask

    task automatic test_alu_ops();
        rtype_op("slt_neg",  6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
        rtype_op("slt_pos",  6'b101010, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0);
        rtype_op("sll",      6'b000000, 32'd0, 32'd1, 5'd4, 32'd16);
        rtype_op("srl",      6'b000010, 32'd0, 32'h8000_0000, 5'd31, 32'd1);
        rtype_op("sub_wrap", 6'b100010, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE);
        rtype_op("and",      6'b100100, 32'hF0F0, 32'hFF00, 5'd0, 32'hF000);
        rtype_op("nor",      6'b100111, 32'hFFFF_0000, 32'h0000_00FF, 5'd0, 32'h0000_FF00);
        rtype_op("bad_fn",   6'b111111, 32'd5, 32'd7, 5'd0, 32'd0);
        idle_inputs();
        aluop = 2'b01; reg1 = 32'd10; reg2 = 32'd3; rs = 5'd10; rt = 5'd11;
        #1;
        n_checks++;
        if (alu_result_ex !== 32'd7) begin
            n_fail++; $display("FAIL aluop_sub: got %h expected 7", alu_result_ex);
        end
        idle_inputs();
        aluop = 2'b11; alusrc = 1'b1; reg1 = 32'hF0; imm_ext = 32'h0F; reg2 = 32'h1; rs = 5'd10;
        rt = 5'd11;
        #1;
        n_checks++;
        if (alu_result_ex !== 32'hFF) begin
            n_fail++; $display("FAIL ori: got %h expected ff", alu_result_ex);
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        aluop = 2'b10; funct = 6'b100000; reg1 = 32'd2; reg2 = 32'd3; rs = 5'd1; rt = 5'd2;
        regdst = 1'b1; rd = 5'd7; regwrite_in = 1'b1;
        tick();
        rs = 5'd7; rt = 5'd7; reg1 = 32'd0; reg2 = 32'd0; rd = 5'd8;
        tick();
        n_checks++;
        if (mem_alu_result !== 32'd10 || mem_dst !== 5'd8) begin
            n_fail++;
            $display("FAIL b2b: got %0d dst %0d expected 10 dst 8", mem_alu_result, mem_dst);
        end
        // Bubble: regwrite 0 in MEM, so rs=8 reads the stale register value.
        idle_inputs();
        tick();
        aluop = 2'b10; funct = 6'b100000; rs = 5'd8; reg1 = 32'd1; rt = 5'd0;
        #1;
        n_checks++;
        if (alu_result_ex !== 32'd1) begin
            n_fail++; $display("FAIL bubble_no_fwd: got %0d expected 1", alu_result_ex);
        end
    endtask

    task automatic test_midstream_reset();
        idle_inputs();
        aluop = 2'b00; alusrc = 1'b1; reg1 = 32'h40; imm_ext = 32'h4; rt = 5'd9; rs = 5'd1;
        reg2 = 32'h1234; memread_in = 1'b1; memtoreg_in = 1'b1; regwrite_in = 1'b1;
        reset = 1'b1;
        tick();
        n_checks++;
        if ({mem_alu_result, mem_store_data, mem_dst, mem_memtoreg, mem_memread, mem_memwrite,
             mem_regwrite} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h/%h/%h/%b%b%b%b expected all zero", mem_alu_result,
                     mem_store_data, mem_dst, mem_memtoreg, mem_memread, mem_memwrite,
                     mem_regwrite);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (mem_alu_result !== 32'h44 || mem_dst !== 5'd9 || mem_store_data !== 32'h1234) begin
            n_fail++;
            $display("FAIL post_reset: got %h dst %0d sd %h expected 44 dst 9 sd 1234",
                     mem_alu_result, mem_dst, mem_store_data);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_rtype_add();
        test_mem_forward();
        test_wb_store();
        test_lw();
        test_r0_no_forward();
        test_alu_ops();
        test_back_to_back();
        test_midstream_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
